// File: rtl/rf_pkg.sv
// rf_pkg: default geometry and select-legality helper shared by the bypass
// register file and its read ports.
package rf_pkg;
   localparam int DATA_W_DEF   = 16;
   localparam int NUM_REGS_DEF = 8;
   localparam int SEL_W_DEF    = 3;
   function automatic logic sel_legal(input int unsigned sel, input int unsigned num_regs,
                                      input bit zero_reg);
      return sel < num_regs && !(zero_reg && sel == 0);
   endfunction
endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one read port -- select mux, range/hard-zero masking,
// same-cycle write forwarding and scoreboard busy flag.
module rf_read_port import rf_pkg::*; #(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int SEL_W    = SEL_W_DEF,
   parameter bit ZERO_REG = 1'b0,
   parameter bit BYPASS   = 1'b1
) (
   input  logic [SEL_W-1:0]  sel_i,
   input  logic [DATA_W-1:0] regs_i [NUM_REGS],
   input  logic              pend_i [NUM_REGS],
   input  logic              wr_legal_i,
   input  logic [SEL_W-1:0]  wr_sel_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              alloc_legal_i,
   input  logic [SEL_W-1:0]  alloc_sel_i,
   output logic [DATA_W-1:0] data_o,
   output logic              busy_o
);
   logic [DATA_W-1:0] reg_val;
   logic              pend, legal, fwd, alloc_same;
   always_comb begin
      reg_val = '0;
      pend    = 1'b0;
      for (int i = 0; i < NUM_REGS; i++)
         if (sel_i == SEL_W'(i)) begin
            reg_val = regs_i[i];
            pend    = pend_i[i];
         end
   end
   assign legal      = sel_legal(32'(sel_i), NUM_REGS, ZERO_REG);
   assign fwd        = BYPASS && wr_legal_i && wr_sel_i == sel_i;
   assign alloc_same = alloc_legal_i && alloc_sel_i == sel_i;
   assign data_o     = !legal ? '0 : fwd ? wr_data_i : reg_val;
   // a writeback only hides the hazard when no new producer claims the register
   assign busy_o     = legal && pend && !(fwd && !alloc_same);
endmodule

// File: rtl/rf_bypass_sb.sv
// rf_bypass_sb: parametrised 2R/1W register file with write-to-read bypass,
// pending-write scoreboard for hazard detection and sticky access error.
module rf_bypass_sb import rf_pkg::*; #(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int SEL_W    = SEL_W_DEF,
   parameter bit ZERO_REG = 1'b0,
   parameter bit BYPASS   = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [SEL_W-1:0]  read1regsel_i,
   input  logic [SEL_W-1:0]  read2regsel_i,
   input  logic [SEL_W-1:0]  writeregsel_i,
   input  logic [DATA_W-1:0] writedata_i,
   input  logic              write_i,
   input  logic              alloc_i,
   input  logic [SEL_W-1:0]  allocregsel_i,
   output logic [DATA_W-1:0] read1data_o,
   output logic [DATA_W-1:0] read2data_o,
   output logic              read1busy_o,
   output logic              read2busy_o,
   output logic              err_o,
   output logic              err_sticky_o
);
   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic              pend_q [NUM_REGS];
   logic              pend_d [NUM_REGS];
   logic              wr_legal, alloc_legal, alloc_pend, err_sticky_q;
   // qualifying with reset keeps bypass, busy and err quiet while rst_ni is low
   assign wr_legal    = rst_ni && write_i && sel_legal(32'(writeregsel_i), NUM_REGS, ZERO_REG);
   assign alloc_legal = rst_ni && alloc_i && sel_legal(32'(allocregsel_i), NUM_REGS, ZERO_REG);
   always_comb begin
      alloc_pend = 1'b0;
      for (int i = 0; i < NUM_REGS; i++)
         if (allocregsel_i == SEL_W'(i)) alloc_pend = pend_q[i];
   end
   assign err_o = rst_ni && ((write_i && 32'(writeregsel_i) >= NUM_REGS) ||
                             (alloc_i && 32'(allocregsel_i) >= NUM_REGS) ||
                             (alloc_legal && alloc_pend &&
                              !(wr_legal && writeregsel_i == allocregsel_i)));
   for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
      logic wr_hit, al_hit;
      assign wr_hit    = wr_legal && writeregsel_i == SEL_W'(r);
      assign al_hit    = alloc_legal && allocregsel_i == SEL_W'(r);
      assign regs_d[r] = wr_hit ? writedata_i : regs_q[r];
      assign pend_d[r] = al_hit || (pend_q[r] && !wr_hit);
      always_ff @(posedge clk_i or negedge rst_ni)
         if (!rst_ni) begin
            regs_q[r] <= '0;
            pend_q[r] <= 1'b0;
         end else begin
            regs_q[r] <= regs_d[r];
            pend_q[r] <= pend_d[r];
         end
   end
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) err_sticky_q <= 1'b0;
      else         err_sticky_q <= err_sticky_q | err_o;
   assign err_sticky_o = err_sticky_q;
   rf_read_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SEL_W(SEL_W),
                  .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)) u_rd1 (
      .sel_i(read1regsel_i), .regs_i(regs_q), .pend_i(pend_q),
      .wr_legal_i(wr_legal), .wr_sel_i(writeregsel_i), .wr_data_i(writedata_i),
      .alloc_legal_i(alloc_legal), .alloc_sel_i(allocregsel_i),
      .data_o(read1data_o), .busy_o(read1busy_o));
   rf_read_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SEL_W(SEL_W),
                  .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)) u_rd2 (
      .sel_i(read2regsel_i), .regs_i(regs_q), .pend_i(pend_q),
      .wr_legal_i(wr_legal), .wr_sel_i(writeregsel_i), .wr_data_i(writedata_i),
      .alloc_legal_i(alloc_legal), .alloc_sel_i(allocregsel_i),
      .data_o(read2data_o), .busy_o(read2busy_o));
endmodule

// File: tb/tb_rf_bypass_sb.sv
// tb_rf_bypass_sb: drives a default instance (8 regs, bypass) and a variant
// (6 regs, hard-zero r0, no bypass) from shared stimulus.
module tb_rf_bypass_sb;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [2:0]  r1sel = '0, r2sel = '0, wsel = '0, asel = '0;
   logic [15:0] wdata = '0;
   logic        wr = 1'b0, alloc = 1'b0;
   logic [15:0] rd1, rd2, z_rd1, z_rd2;
   logic        bz1, bz2, err, sticky, z_bz1, z_bz2, z_err, z_sticky;
   int          pass_cnt = 0, total_cnt = 0;
   typedef struct packed { logic [2:0] sel; logic [15:0] data; } wr_t;
   wr_t sb[$];

   always #5 clk = ~clk;

   rf_bypass_sb dut (
      .clk_i(clk), .rst_ni(rst_n), .read1regsel_i(r1sel), .read2regsel_i(r2sel),
      .writeregsel_i(wsel), .writedata_i(wdata), .write_i(wr), .alloc_i(alloc),
      .allocregsel_i(asel), .read1data_o(rd1), .read2data_o(rd2), .read1busy_o(bz1),
      .read2busy_o(bz2), .err_o(err), .err_sticky_o(sticky));

   rf_bypass_sb #(.NUM_REGS(6), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_z (
      .clk_i(clk), .rst_ni(rst_n), .read1regsel_i(r1sel), .read2regsel_i(r2sel),
      .writeregsel_i(wsel), .writedata_i(wdata), .write_i(wr), .alloc_i(alloc),
      .allocregsel_i(asel), .read1data_o(z_rd1), .read2data_o(z_rd2), .read1busy_o(z_bz1),
      .read2busy_o(z_bz2), .err_o(z_err), .err_sticky_o(z_sticky));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) begin
         r1sel = 3'(i);
         r2sel = 3'(7 - i);
         #1;
         total_cnt++; if (rd1 !== 16'h0) $display("FAIL reset_rd1[%0d] got %h exp 0000", i, rd1); else pass_cnt++;
         total_cnt++; if (rd2 !== 16'h0) $display("FAIL reset_rd2[%0d] got %h exp 0000", i, rd2); else pass_cnt++;
         total_cnt++; if ({bz1, bz2, err, sticky} !== 4'b0) $display("FAIL reset_flags[%0d] got %b exp 0000", i, {bz1, bz2, err, sticky}); else pass_cnt++;
      end
   endtask

   task automatic test_bypass();
      wr = 1'b1; wsel = 3'd3; wdata = 16'hBEEF; r1sel = 3'd3;
      #1;
      total_cnt++; if (rd1 !== 16'hBEEF) $display("FAIL bypass_same_cycle got %h exp BEEF", rd1); else pass_cnt++;
      total_cnt++; if (z_rd1 !== 16'h0) $display("FAIL nobypass_same_cycle got %h exp 0000", z_rd1); else pass_cnt++;
      tick();
      wr = 1'b0;
      #1;
      total_cnt++; if (rd1 !== 16'hBEEF) $display("FAIL bypass_stored got %h exp BEEF", rd1); else pass_cnt++;
      total_cnt++; if (z_rd1 !== 16'hBEEF) $display("FAIL nobypass_stored got %h exp BEEF", z_rd1); else pass_cnt++;
   endtask

   task automatic test_scoreboard();
      alloc = 1'b1; asel = 3'd5;
      tick();
      alloc = 1'b0; r2sel = 3'd5;
      #1;
      total_cnt++; if (bz2 !== 1'b1) $display("FAIL busy_after_alloc got %b exp 1", bz2); else pass_cnt++;
      total_cnt++; if (z_bz2 !== 1'b1) $display("FAIL z_busy_after_alloc got %b exp 1", z_bz2); else pass_cnt++;
      wr = 1'b1; wsel = 3'd5; wdata = 16'h1234;
      #1;
      total_cnt++; if (bz2 !== 1'b0) $display("FAIL busy_writeback got %b exp 0", bz2); else pass_cnt++;
      total_cnt++; if (z_bz2 !== 1'b1) $display("FAIL z_busy_writeback got %b exp 1", z_bz2); else pass_cnt++;
      total_cnt++; if (rd2 !== 16'h1234) $display("FAIL rd2_writeback got %h exp 1234", rd2); else pass_cnt++;
      tick();
      wr = 1'b0;
      #1;
      total_cnt++; if ({bz2, z_bz2} !== 2'b00) $display("FAIL busy_cleared got %b exp 00", {bz2, z_bz2}); else pass_cnt++;
      total_cnt++; if (z_rd2 !== 16'h1234) $display("FAIL z_rd2_stored got %h exp 1234", z_rd2); else pass_cnt++;
      alloc = 1'b1; wr = 1'b1; wdata = 16'h5678;
      #1;
      total_cnt++; if (bz2 !== 1'b0) $display("FAIL busy_alloc_write_idle got %b exp 0", bz2); else pass_cnt++;
      tick();
      alloc = 1'b0; wr = 1'b0;
      #1;
      total_cnt++; if ({bz2, z_bz2} !== 2'b11) $display("FAIL alloc_wins got %b exp 11", {bz2, z_bz2}); else pass_cnt++;
      alloc = 1'b1; wr = 1'b1; wdata = 16'h9ABC;
      #1;
      total_cnt++; if ({err, z_err} !== 2'b00) $display("FAIL realloc_with_write_err got %b exp 00", {err, z_err}); else pass_cnt++;
      total_cnt++; if (bz2 !== 1'b1) $display("FAIL busy_realloc_with_write got %b exp 1", bz2); else pass_cnt++;
      tick();
      alloc = 1'b0;
      tick();
      wr = 1'b0;
      #1;
      total_cnt++; if ({bz2, z_bz2, sticky} !== 3'b000) $display("FAIL sb_final got %b exp 000", {bz2, z_bz2, sticky}); else pass_cnt++;
      total_cnt++; if (rd2 !== 16'h9ABC) $display("FAIL rd2_final got %h exp 9ABC", rd2); else pass_cnt++;
   endtask

   task automatic test_double_alloc();
      alloc = 1'b1; asel = 3'd2;
      #1;
      total_cnt++; if (err !== 1'b0) $display("FAIL first_alloc_err got %b exp 0", err); else pass_cnt++;
      tick();
      #1;
      total_cnt++; if ({err, z_err} !== 2'b11) $display("FAIL waw_err got %b exp 11", {err, z_err}); else pass_cnt++;
      total_cnt++; if (sticky !== 1'b0) $display("FAIL sticky_same_cycle got %b exp 0", sticky); else pass_cnt++;
      tick();
      alloc = 1'b0;
      #1;
      total_cnt++; if ({err, sticky, z_sticky} !== 3'b011) $display("FAIL sticky_set got %b exp 011", {err, sticky, z_sticky}); else pass_cnt++;
      repeat (3) tick();
      total_cnt++; if (sticky !== 1'b1) $display("FAIL sticky_held got %b exp 1", sticky); else pass_cnt++;
   endtask

   task automatic test_range_zero();
      wr = 1'b1; wsel = 3'd7; wdata = 16'hAAAA; r1sel = 3'd7;
      #1;
      total_cnt++; if ({z_err, err} !== 2'b10) $display("FAIL range_err got %b exp 10", {z_err, err}); else pass_cnt++;
      total_cnt++; if (z_rd1 !== 16'h0) $display("FAIL z_rd_sel7 got %h exp 0000", z_rd1); else pass_cnt++;
      total_cnt++; if (rd1 !== 16'hAAAA) $display("FAIL rd_sel7_bypass got %h exp AAAA", rd1); else pass_cnt++;
      tick();
      wr = 1'b0; r1sel = 3'd3;
      #1;
      total_cnt++; if (z_rd1 !== 16'hBEEF) $display("FAIL z_r3_unchanged got %h exp BEEF", z_rd1); else pass_cnt++;
      wr = 1'b1; wsel = 3'd0; wdata = 16'h5555; r1sel = 3'd0;
      #1;
      total_cnt++; if (z_err !== 1'b0) $display("FAIL zero_write_err got %b exp 0", z_err); else pass_cnt++;
      total_cnt++; if (z_rd1 !== 16'h0) $display("FAIL zero_read_wcycle got %h exp 0000", z_rd1); else pass_cnt++;
      tick();
      wr = 1'b0;
      #1;
      total_cnt++; if (z_rd1 !== 16'h0) $display("FAIL zero_read_after got %h exp 0000", z_rd1); else pass_cnt++;
      total_cnt++; if (rd1 !== 16'h5555) $display("FAIL r0_normal got %h exp 5555", rd1); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      wr_t e;
      for (int i = 1; i <= 4; i++) begin
         e.sel = 3'(i);
         e.data = 16'($urandom);
         wr = 1'b1; wsel = e.sel; wdata = e.data;
         sb.push_back(e);
         tick();
      end
      wr = 1'b0;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         r1sel = e.sel; r2sel = e.sel;
         #1;
         total_cnt++; if (rd1 !== e.data) $display("FAIL b2b_rd1[%0d] got %h exp %h", e.sel, rd1, e.data); else pass_cnt++;
         total_cnt++; if (rd2 !== e.data) $display("FAIL b2b_rd2[%0d] got %h exp %h", e.sel, rd2, e.data); else pass_cnt++;
         total_cnt++; if (z_rd1 !== e.data) $display("FAIL b2b_z_rd1[%0d] got %h exp %h", e.sel, z_rd1, e.data); else pass_cnt++;
      end
   endtask

   task automatic test_async_reset();
      wr = 1'b1; wsel = 3'd1; wdata = 16'h00FF;
      tick();
      wr = 1'b0; alloc = 1'b1; asel = 3'd4;
      tick();
      alloc = 1'b0; r1sel = 3'd1; r2sel = 3'd4;
      #1;
      total_cnt++; if ({rd1, bz2} !== {16'h00FF, 1'b1}) $display("FAIL pre_reset got %h/%b exp 00ff/1", rd1, bz2); else pass_cnt++;
      rst_n = 1'b0;
      #1;
      total_cnt++; if (rd1 !== 16'h0) $display("FAIL async_rd1 got %h exp 0000", rd1); else pass_cnt++;
      total_cnt++; if ({bz2, z_bz2, sticky, z_sticky, err} !== 5'b0) $display("FAIL async_flags got %b exp 00000", {bz2, z_bz2, sticky, z_sticky, err}); else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      total_cnt++; if ({rd1, bz2} !== 17'h0) $display("FAIL post_reset got %h/%b exp 0000/0", rd1, bz2); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_scoreboard();
      test_double_alloc();
      test_range_zero();
      test_back_to_back();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
endmodule
